// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with valid/ready handshakes, shifts and optional shift-add multiplier.
// Define ALU_MULTICYCLE_MUL_EN to build MUL (control 8); otherwise control 8 decodes as illegal.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] t,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             cout,
  output logic             illegal
);

`ifdef ALU_MULTICYCLE_MUL_EN
  typedef enum logic {IDLE, MULT} state_t;
`else
  typedef enum logic {IDLE} state_t;
`endif

  state_t           state, state_next;
  logic             accept, is_mul, load_alu;
  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf, alu_cout, alu_ill, slt;

  assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign load_alu = accept && !is_mul;

  // SLT takes the sign of s when signs differ, so s-t overflow cannot corrupt it
  assign slt = (s[WIDTH-1] != t[WIDTH-1]) ? s[WIDTH-1] : sub_full[WIDTH-1];

  always_comb begin
    add_full = {1'b0, s} + {1'b0, t};
    sub_full = {1'b0, s} + {1'b0, ~t} + {{WIDTH{1'b0}}, 1'b1};
    alu_res  = '0;
    alu_ovf  = 1'b0;
    alu_cout = 1'b0;
    alu_ill  = 1'b0;
    case (control)
      4'h0: alu_res = s & t;
      4'h1: alu_res = s | t;
      4'h2: begin
        alu_res  = add_full[WIDTH-1:0];
        alu_ovf  = (s[WIDTH-1] == t[WIDTH-1]) && (add_full[WIDTH-1] != s[WIDTH-1]);
        alu_cout = add_full[WIDTH];
      end
      4'h3: begin
        alu_res  = sub_full[WIDTH-1:0];
        alu_ovf  = (s[WIDTH-1] != t[WIDTH-1]) && (sub_full[WIDTH-1] != s[WIDTH-1]);
        alu_cout = sub_full[WIDTH];
      end
      4'h4: alu_res = s << t[SHW-1:0];
      4'h5: alu_res = s >> t[SHW-1:0];
      4'h7: alu_res = {{(WIDTH-1){1'b0}}, slt};
      4'hC: alu_res = ~(s | t);
`ifdef ALU_MULTICYCLE_MUL_EN
      4'h8: alu_res = '0;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_MULTICYCLE_MUL_EN
  logic [WIDTH-1:0]   mcand, prod_hi, prod_lo;
  logic [SHW-1:0]     cnt;
  logic [WIDTH:0]     partial;
  logic [2*WIDTH-1:0] prod_next;
  logic               mul_done;

  assign is_mul = (control == 4'h8);

  always_comb begin
    partial    = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : '0);
    prod_next  = {partial, prod_lo[WIDTH-1:1]};
    mul_done   = (state == MULT) && (cnt == SHW'(WIDTH - 1));
    state_next = state;
    case (state)
      IDLE:    if (accept && is_mul) state_next = MULT;
      MULT:    if (mul_done)         state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      prod_hi <= '0;
      prod_lo <= '0;
      cnt     <= '0;
    end else if (accept && is_mul) begin
      mcand   <= s;
      prod_hi <= '0;
      prod_lo <= t;
      cnt     <= '0;
    end else if (state == MULT) begin
      {prod_hi, prod_lo} <= prod_next;
      cnt                <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           result_hi <= '0;
    else if (load_alu) result_hi <= '0;
    else if (mul_done) result_hi <= prod_next[2*WIDTH-1:WIDTH];
  end
`else
  assign is_mul    = 1'b0;
  assign result_hi = '0;

  always_comb state_next = IDLE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A new result may load on the same edge the held one is consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      cout      <= 1'b0;
      illegal   <= 1'b0;
    end else if (load_alu) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      zero      <= (alu_res == '0);
      overflow  <= alu_ovf;
      cout      <= alu_cout;
      illegal   <= alu_ill;
`ifdef ALU_MULTICYCLE_MUL_EN
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= prod_next[WIDTH-1:0];
      zero      <= (prod_next[WIDTH-1:0] == '0);
      overflow  <= (prod_next[2*WIDTH-1:WIDTH] != '0);
      cout      <= 1'b0;
      illegal   <= 1'b0;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
